// File: rtl/controller_poller_if.sv
// Bundle of the controller link and button-word signals shared by the poller and its user.
// The master side is the poller; the slave side drives start/ser_data and observes the rest.
interface controller_poller_if;
    logic        start;
    logic [1:0]  ser_data;
    logic        latch;
    logic        pulse;
    logic        busy;
    logic [15:0] buttons_p1;
    logic [15:0] buttons_p2;
    logic        valid;

    modport master (
        input  start,
        input  ser_data,
        output latch,
        output pulse,
        output busy,
        output buttons_p1,
        output buttons_p2,
        output valid
    );

    modport slave (
        output start,
        output ser_data,
        input  latch,
        input  pulse,
        input  busy,
        input  buttons_p1,
        input  buttons_p2,
        input  valid
    );
endinterface

// File: rtl/controller_poller.sv
// Polls two SNES-style controllers: latch pulse, 16 serial clock periods, then publishes
// both button words (1 = pressed) with a one-cycle valid strobe.
module controller_poller #(
    parameter int CLK_DIV  = 300,
    parameter int POLL_GAP = 833000
) (
    input  logic                 clock,
    input  logic                 reset,
    controller_poller_if.master  pif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int PH_W  = $clog2(2 * CLK_DIV);

    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(POLL_GAP - 1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_HIGH   = PH_W'(CLK_DIV);

    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [3:0]       bit_q, bit_d;
    logic             latch_q, latch_d;
    logic             pulse_q, pulse_d;
    logic             valid_q, valid_d;
    logic             capture_en;
    logic             load_en;
    logic [1:0][15:0] buttons_w;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            latch_q <= 1'b0;
            pulse_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            latch_q <= latch_d;
            pulse_q <= pulse_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        capture_en = 1'b0;
        load_en    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pif.start || (gap_q == GAP_LAST)) begin
                    state_d = ST_LATCH;
                    gap_d   = '0;
                    phase_d = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_LATCH: begin
                if (phase_q == PH_LAST) begin
                    state_d = ST_SHIFT;
                    phase_d = '0;
                    bit_d   = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                // Sample at the end of the low phase, just before the rising pulse edge
                // tells the controller to present its next bit.
                capture_en = (phase_q == PH_SAMPLE);
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (bit_q == 4'd15) begin
                        state_d = ST_DONE;
                        load_en = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line outputs are registered from the next state so they align with state_q glitch-free.
        latch_d = (state_d == ST_LATCH);
        pulse_d = !((state_d == ST_SHIFT) && (phase_d < PH_HIGH));
        valid_d = (state_d == ST_DONE);
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_player
        logic        sync1_q, sync1_d;
        logic        sync2_q, sync2_d;
        logic [15:0] sr_q, sr_d;
        logic [15:0] btn_q, btn_d;

        always_comb begin
            sync1_d = pif.ser_data[gi];
            sync2_d = sync1_q;
            sr_d    = sr_q;
            if (capture_en) begin
                sr_d[bit_q] = ~sync2_q;
            end
            // Bit 15 was captured in an earlier cycle, so sr_q is complete on load.
            btn_d = load_en ? sr_q : btn_q;
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                sr_q    <= '0;
                btn_q   <= '0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                sr_q    <= sr_d;
                btn_q   <= btn_d;
            end
        end

        assign buttons_w[gi] = btn_q;
    end

    assign pif.latch      = latch_q;
    assign pif.pulse      = pulse_q;
    assign pif.valid      = valid_q;
    assign pif.busy       = (state_q != ST_IDLE);
    assign pif.buttons_p1 = buttons_w[0];
    assign pif.buttons_p2 = buttons_w[1];

endmodule

// File: tb/tb_controller_poller.sv
// Directed bench for controller_poller with CLK_DIV=4, POLL_GAP=100 and a behavioural
// pair of controllers that shift out their patterns on each rising pulse edge.
module tb_controller_poller;

    localparam int D   = 4;
    localparam int GAP = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    controller_poller_if pif();

    controller_poller #(.CLK_DIV(D), .POLL_GAP(GAP)) dut (
        .clock (clk),
        .reset (rst),
        .pif   (pif)
    );

    typedef struct {
        logic [15:0] p1;
        logic [15:0] p2;
        logic [15:0] exp_p1;
        logic [15:0] exp_p2;
    } vec_t;

    vec_t vecs [5];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: latch reloads bit 0, each rising pulse edge advances one bit.
    logic [15:0] p1_pat = 16'h0000;
    logic [15:0] p2_pat = 16'h0000;
    int          idx = 0;
    logic        m_prev_pulse = 1'b1;
    logic        ovr_en = 1'b0;
    logic [1:0]  ovr_val = 2'b11;

    assign pif.ser_data = ovr_en ? ovr_val :
                          (idx < 16) ? {~p2_pat[idx[3:0]], ~p1_pat[idx[3:0]]} : 2'b11;

    initial begin
        forever begin
            @(negedge clk);
            if (pif.latch) idx = 0;
            else if (pif.pulse && !m_prev_pulse) idx = idx + 1;
            m_prev_pulse = pif.pulse;
        end
    end

    // Line monitor: per-poll latch length, pulse low periods and valid count.
    int   lat_cnt = 0, low_periods = 0, bad_low = 0, low_len = 0, valid_cnt = 0, overlap = 0;
    logic mon_prev_latch = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (pif.latch && !mon_prev_latch) begin
                lat_cnt = 0; low_periods = 0; bad_low = 0; low_len = 0; valid_cnt = 0;
            end
            if (pif.latch) lat_cnt++;
            if (!pif.pulse) low_len++;
            else if (low_len > 0) begin
                low_periods++;
                if (low_len != D) bad_low++;
                low_len = 0;
            end
            if (pif.valid) valid_cnt++;
            if (pif.latch && !pif.pulse) overlap++;
            mon_prev_latch = pif.latch;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    task automatic start_poll(output int t0);
        @(negedge clk);
        pif.start = 1'b1;
        @(posedge clk);
        #1 pif.start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pif.valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("valid timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_latch(input int budget, output int t);
        logic prev;
        prev = 1'b1;
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pif.latch && !prev) begin
                t = cyc;
                break;
            end
            prev = pif.latch;
        end
        if (t < 0) check("latch timeout", 32'd0, 32'd1);
    endtask

    task automatic run_row(input vec_t v);
        int t0;
        bit ok;
        p1_pat = v.p1;
        p2_pat = v.p2;
        ovr_en = 1'b0;
        check("idle before start", pif.busy, 1'b0);
        start_poll(t0);
        wait_valid(300, ok);
        if (ok) begin
            check("valid cycle", cyc - t0, 32'd136);
            check("busy in done", pif.busy, 1'b1);
            check("buttons_p1", pif.buttons_p1, v.exp_p1);
            check("buttons_p2", pif.buttons_p2, v.exp_p2);
            @(posedge clk);
            #1;
            check("valid one wide", pif.valid, 1'b0);
            check("idle after done", pif.busy, 1'b0);
            check("latch cycles", lat_cnt, 32'd8);
            check("pulse low periods", low_periods, 32'd16);
            check("bad low lengths", bad_low, 32'd0);
            check("valids per poll", valid_cnt, 32'd1);
        end
    endtask

    initial begin
        forever begin
            #400000;
            $display("FAIL watchdog: time %0t limit 400000", $time);
            $fatal(1, "watchdog expired");
        end
    end

    initial begin
        int  t0, t1, ta, tb_lat, n;
        bit  ok;

        vecs[0] = '{16'hA5C3, 16'h0001, 16'hA5C3, 16'h0001};
        vecs[1] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[2] = '{16'h0000, 16'h8000, 16'h0000, 16'h8000};
        vecs[3] = '{16'hFFFF, 16'h1234, 16'hFFFF, 16'h1234};
        vecs[4] = '{16'h5A3C, 16'hF00F, 16'h5A3C, 16'hF00F};

        pif.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset latch", pif.latch, 1'b0);
        check("reset pulse", pif.pulse, 1'b1);
        check("reset busy", pif.busy, 1'b0);
        check("reset valid", pif.valid, 1'b0);
        check("reset p1", pif.buttons_p1, 16'h0000);
        check("reset p2", pif.buttons_p2, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            $display("row %0d p1=%h p2=%h", i, vecs[i].p1, vecs[i].p2);
            run_row(vecs[i]);
        end

        // Hold between polls, start ignored while busy, normal gap afterwards.
        repeat (40) @(posedge clk);
        #1;
        check("hold idle p1", pif.buttons_p1, 16'h5A3C);
        check("hold idle p2", pif.buttons_p2, 16'hF00F);
        p1_pat = 16'h1111;
        p2_pat = 16'h2222;
        start_poll(t0);
        repeat (20) @(posedge clk);
        #1 pif.start = 1'b1;
        @(posedge clk);
        #1 pif.start = 1'b0;
        repeat (79) @(posedge clk);
        #1;
        check("hold mid poll p1", pif.buttons_p1, 16'h5A3C);
        check("hold mid poll p2", pif.buttons_p2, 16'hF00F);
        repeat (30) @(posedge clk);
        #1 pif.start = 1'b1;
        @(posedge clk);
        #1 pif.start = 1'b0;
        wait_valid(300, ok);
        if (ok) begin
            check("start drop valid cycle", cyc - t0, 32'd136);
            check("start drop p1", pif.buttons_p1, 16'h1111);
            check("start drop p2", pif.buttons_p2, 16'h2222);
        end
        wait_latch(400, t1);
        check("gap after busy start", t1 - t0, 32'd237);

        // Autonomous repeat.
        ta = t1;
        wait_valid(300, ok);
        @(posedge clk);
        #1;
        check("auto valids per poll", valid_cnt, 32'd1);
        check("auto p1", pif.buttons_p1, 16'h1111);
        wait_latch(400, tb_lat);
        check("auto period", tb_lat - ta, 32'd237);

        // Reset in the middle of SHIFT (cycle 50, bit 5 low phase).
        for (int i = 0; i < 100; i++) begin
            if (cyc == tb_lat + 50) break;
            @(negedge clk);
        end
        check("pulse low at cycle 50", pif.pulse, 1'b0);
        rst = 1'b1;
        #1;
        check("midreset latch", pif.latch, 1'b0);
        check("midreset pulse", pif.pulse, 1'b1);
        check("midreset busy", pif.busy, 1'b0);
        check("midreset valid", pif.valid, 1'b0);
        check("midreset p1", pif.buttons_p1, 16'h0000);
        check("midreset p2", pif.buttons_p2, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (pif.latch) begin
                n = i;
                break;
            end
        end
        check("first auto latch after reset", n, 32'd100);
        wait_valid(300, ok);

        // Data edge 1 cycle before the bit 0 sample (cycle 11): old value captured.
        ovr_en = 1'b1;
        ovr_val = 2'b11;
        start_poll(t0);
        repeat (10) @(posedge clk);
        #1 ovr_val = 2'b00;
        wait_valid(300, ok);
        if (ok) begin
            check("late edge p1", pif.buttons_p1, 16'hFFFE);
            check("late edge p2", pif.buttons_p2, 16'hFFFE);
        end

        // Data edge 3 cycles before the sample: new value captured.
        ovr_val = 2'b11;
        start_poll(t0);
        repeat (8) @(posedge clk);
        #1 ovr_val = 2'b00;
        wait_valid(300, ok);
        if (ok) begin
            check("early edge p1", pif.buttons_p1, 16'hFFFF);
            check("early edge p2", pif.buttons_p2, 16'hFFFF);
        end

        check("latch with pulse low", overlap, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
